// File: rtl/dcache_fill_pkg.sv
// ---------------------------------------------------------------------------
// dcache_fill_pkg : shared types and constants for the D-cache fill unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_fill_pkg;

   localparam int LINE_WORDS      = 4;
   localparam int WORD_OFF_BITS   = 2;
   localparam int CACHE_TYPE_BITS = 3;

   // Word access code, matching the byte/half/word ordering of the cache type field
   localparam logic [CACHE_TYPE_BITS-1:0] CACHE_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_DRAIN = 2'd1,
      ST_RD_BEAT  = 2'd2,
      ST_RD_DONE  = 2'd3
   } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/fill_line_assembler.sv
// ---------------------------------------------------------------------------
// fill_line_assembler : refill line register written one word slot at a time
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fill_line_assembler #(
   parameter int LINE_WORDS = 4,
   parameter int WORD_BITS  = 32,
   parameter int SLOT_BITS  = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_we,
   input  logic [SLOT_BITS-1:0]            i_slot,
   input  logic [WORD_BITS-1:0]            i_wdata,
   output logic [LINE_WORDS*WORD_BITS-1:0] o_line
);

   logic [WORD_BITS-1:0] r_word [LINE_WORDS];

   for (genvar i = 0; i < LINE_WORDS; i++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_word[i] <= '0;
         end else if (i_we && (i_slot == SLOT_BITS'(i))) begin
            r_word[i] <= i_wdata;
         end
      end

      assign o_line[i*WORD_BITS +: WORD_BITS] = r_word[i];
   end

endmodule

`default_nettype wire

// File: rtl/dcache_mem_fill_unit.sv
// ---------------------------------------------------------------------------
// dcache_mem_fill_unit : critical-word-first line refill and 1-entry posted write buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_mem_fill_unit #(
   parameter int ADDR_BITS  = 32,
   parameter int LINE_WORDS = dcache_fill_pkg::LINE_WORDS
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        req_valid,
   input  logic                                        req_write,
   input  logic [ADDR_BITS-1:0]                        req_addr,
   input  logic [31:0]                                 req_wdata,
   input  logic [dcache_fill_pkg::CACHE_TYPE_BITS-1:0] req_type,
   output logic                                        req_wait,
   output logic [32*LINE_WORDS-1:0]                    line_out,
   output logic                                        line_valid,
   output logic                                        mem_req,
   output logic                                        mem_write,
   output logic [ADDR_BITS-1:0]                        mem_addr,
   output logic [31:0]                                 mem_wdata,
   output logic [dcache_fill_pkg::CACHE_TYPE_BITS-1:0] mem_type,
   input  logic                                        mem_wait,
   input  logic [31:0]                                 mem_rdata
);

   import dcache_fill_pkg::*;

   localparam int BASE_BITS = ADDR_BITS - WORD_OFF_BITS - 2;

   fill_state_t                r_state;
   fill_state_t                w_next;
   logic                       r_wbuf_full;
   logic [ADDR_BITS-1:0]       r_wb_addr;
   logic [31:0]                r_wb_data;
   logic [CACHE_TYPE_BITS-1:0] r_wb_type;
   logic [BASE_BITS-1:0]       r_base;
   logic [WORD_OFF_BITS-1:0]   r_start;
   logic [WORD_OFF_BITS-1:0]   r_beat_cnt;

   logic                       w_wr_accept;
   logic                       w_rd_accept;
   logic                       w_beat_done;
   logic                       w_drain_done;
   logic [WORD_OFF_BITS-1:0]   w_slot;

   assign w_wr_accept  = (r_state == ST_IDLE) & req_valid &  req_write & ~r_wbuf_full;
   assign w_rd_accept  = (r_state == ST_IDLE) & req_valid & ~req_write & ~r_wbuf_full;
   assign w_beat_done  = (r_state == ST_RD_BEAT)  & ~mem_wait;
   assign w_drain_done = (r_state == ST_WR_DRAIN) & ~mem_wait;
   // Offset arithmetic wraps naturally in WORD_OFF_BITS, giving critical-word-first order
   assign w_slot       = r_start + r_beat_cnt;

   assign req_wait = req_valid & ~(w_wr_accept | line_valid);

   always_comb begin
      w_next     = r_state;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_type   = '0;
      line_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A buffered write drains before any new request, preserving read-after-write order
            if (r_wbuf_full)      w_next = ST_WR_DRAIN;
            else if (w_rd_accept) w_next = ST_RD_BEAT;
         end
         ST_WR_DRAIN: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            mem_addr  = r_wb_addr;
            mem_wdata = r_wb_data;
            mem_type  = r_wb_type;
            if (!mem_wait) w_next = ST_IDLE;
         end
         ST_RD_BEAT: begin
            mem_req  = 1'b1;
            mem_addr = {r_base, w_slot, 2'b00};
            mem_type = CACHE_WORD;
            if (!mem_wait && (r_beat_cnt == WORD_OFF_BITS'(LINE_WORDS - 1))) w_next = ST_RD_DONE;
         end
         ST_RD_DONE: begin
            line_valid = 1'b1;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_wbuf_full <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_wb_type   <= '0;
         r_base      <= '0;
         r_start     <= '0;
         r_beat_cnt  <= '0;
      end else begin
         r_state <= w_next;

         if (w_wr_accept) begin
            r_wbuf_full <= 1'b1;
            r_wb_addr   <= req_addr;
            r_wb_data   <= req_wdata;
            r_wb_type   <= req_type;
         end else if (w_drain_done) begin
            r_wbuf_full <= 1'b0;
         end

         if (w_rd_accept) begin
            r_base     <= req_addr[ADDR_BITS-1:WORD_OFF_BITS+2];
            r_start    <= req_addr[WORD_OFF_BITS+1:2];
            r_beat_cnt <= '0;
         end else if (w_beat_done) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   fill_line_assembler #(
      .LINE_WORDS (LINE_WORDS),
      .WORD_BITS  (32),
      .SLOT_BITS  (WORD_OFF_BITS)
   ) u_line (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_beat_done),
      .i_slot  (w_slot),
      .i_wdata (mem_rdata),
      .o_line  (line_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_dcache_mem_fill_unit.sv
// ---------------------------------------------------------------------------
// tb_dcache_mem_fill_unit : directed self-checking bench for the D-cache fill unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_mem_fill_unit;
   import dcache_fill_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       req_valid;
   logic                       req_write;
   logic [31:0]                req_addr;
   logic [31:0]                req_wdata;
   logic [CACHE_TYPE_BITS-1:0] req_type;
   logic                       req_wait;
   logic [127:0]               line_out;
   logic                       line_valid;
   logic                       mem_req;
   logic                       mem_write;
   logic [31:0]                mem_addr;
   logic [31:0]                mem_wdata;
   logic [CACHE_TYPE_BITS-1:0] mem_type;
   logic                       mem_wait;
   logic [31:0]                mem_rdata;

   int checks   = 0;
   int failures = 0;
   bit found;

   logic [31:0] ea1   [4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
   logic        wait5 [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [31:0] addr5 [6] = '{32'h2000, 32'h2004, 32'h2008, 32'h2008, 32'h2008, 32'h200C};

   always #5 clk = ~clk;

   dcache_mem_fill_unit #(.ADDR_BITS(32), .LINE_WORDS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_type   (req_type),
      .req_wait   (req_wait),
      .line_out   (line_out),
      .line_valid (line_valid),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_type   (mem_type),
      .mem_wait   (mem_wait),
      .mem_rdata  (mem_rdata)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      req_type = '0; mem_wait = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_line_valid", line_valid, 1'b0);
      chk("rst_line_out", line_out, 128'h0);
      chk("rst_req_wait", req_wait, 1'b0);
      rst = 1'b0;

      // Read 0x1008: beats 2,3,0,1, data A0..A3 in beat order
      tick; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1008; req_type = CACHE_WORD; settle;
      chk("rd1_accept_wait", req_wait, 1'b1);
      chk("rd1_accept_noreq", mem_req, 1'b0);
      for (int b = 0; b < 4; b++) begin
         tick; mem_rdata = 32'hA0 + 32'(b); settle;
         chk("rd1_addr", mem_addr, ea1[b]);
         chk("rd1_req", mem_req, 1'b1);
         chk("rd1_write", mem_write, 1'b0);
      end
      chk("rd1_type", mem_type, CACHE_WORD);
      tick; settle;
      chk("rd1_line_valid", line_valid, 1'b1);
      chk("rd1_line_out", line_out, 128'h000000A1_000000A0_000000A3_000000A2);
      chk("rd1_req_drop", mem_req, 1'b0);
      chk("rd1_req_wait_done", req_wait, 1'b0);
      req_valid = 1'b0;
      tick; settle;
      chk("rd1_line_valid_pulse", line_valid, 1'b0);

      // Posted write to 0x4 with a 3-cycle wrapper stall
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
      req_type = CACHE_WORD; mem_wait = 1'b1; settle;
      chk("wr2_posted", req_wait, 1'b0);
      tick; req_valid = 1'b0;
      found = mem_req;
      for (int i = 0; i < 4 && !found; i++) begin tick; found = mem_req; end
      chk("wr2_drain_seen", found, 1'b1);
      for (int k = 0; k < 4; k++) begin
         mem_wait = (k < 3); settle;
         chk("wr2_req", mem_req, 1'b1);
         chk("wr2_write", mem_write, 1'b1);
         chk("wr2_addr", mem_addr, 32'h4);
         chk("wr2_wdata", mem_wdata, 32'hDEADBEEF);
         tick;
      end
      mem_wait = 1'b0; settle;
      chk("wr2_req_drop", mem_req, 1'b0);

      // Write 0x1000 then read 0x1000: the read waits for the drain
      tick; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000; req_wdata = 32'h55; settle;
      chk("raw_wr_posted", req_wait, 1'b0);
      tick; req_write = 1'b0; settle;
      chk("raw_rd_held", req_wait, 1'b1);
      found = mem_req & mem_write;
      for (int i = 0; i < 4 && !found; i++) begin
         chk("raw_no_rd_beat", mem_req & ~mem_write, 1'b0);
         tick; settle; found = mem_req & mem_write;
      end
      chk("raw_drain_seen", found, 1'b1);
      chk("raw_drain_addr", mem_addr, 32'h1000);
      chk("raw_drain_rd_wait", req_wait, 1'b1);
      tick; settle;
      chk("raw_idle_noreq", mem_req, 1'b0);
      chk("raw_idle_wait", req_wait, 1'b1);
      for (int b = 0; b < 4; b++) begin
         tick; mem_rdata = 32'h11 * (b + 1); settle;
         chk("raw_rd_addr", mem_addr, 32'h1000 + 32'(4 * b));
         chk("raw_rd_write", mem_write, 1'b0);
      end
      tick; settle;
      chk("raw_line_valid", line_valid, 1'b1);
      chk("raw_line_out", line_out, 128'h00000044_00000033_00000022_00000011);
      req_valid = 1'b0;

      // Two back-to-back writes
      tick; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1; settle;
      chk("ww_first_posted", req_wait, 1'b0);
      tick; req_addr = 32'h24; req_wdata = 32'h2; settle;
      chk("ww_second_held", req_wait, 1'b1);
      found = mem_req;
      for (int i = 0; i < 4 && !found; i++) begin
         chk("ww_second_still_held", req_wait, 1'b1);
         tick; settle; found = mem_req;
      end
      chk("ww_drain1_seen", found, 1'b1);
      chk("ww_drain1_addr", mem_addr, 32'h20);
      chk("ww_drain1_data", mem_wdata, 32'h1);
      chk("ww_drain1_held", req_wait, 1'b1);
      tick; settle;
      chk("ww_second_accept", req_wait, 1'b0);
      tick; req_valid = 1'b0; settle;
      found = mem_req;
      for (int i = 0; i < 4 && !found; i++) begin tick; settle; found = mem_req; end
      chk("ww_drain2_seen", found, 1'b1);
      chk("ww_drain2_addr", mem_addr, 32'h24);
      chk("ww_drain2_data", mem_wdata, 32'h2);

      // Read 0x2000 with a 2-cycle stall on the third beat
      tick; tick; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000; settle;
      chk("st_accept_wait", req_wait, 1'b1);
      for (int c = 0; c < 6; c++) begin
         tick; mem_wait = wait5[c]; mem_rdata = 32'hB0 + 32'(c); settle;
         chk("st_addr", mem_addr, addr5[c]);
         chk("st_no_line_valid", line_valid, 1'b0);
      end
      mem_wait = 1'b0;
      tick; settle;
      chk("st_line_valid", line_valid, 1'b1);
      chk("st_line_out", line_out, 128'h000000B5_000000B4_000000B1_000000B0);
      req_valid = 1'b0;

      // Asynchronous reset during beat 1 of a read of 0x3004
      tick; req_valid = 1'b1; req_addr = 32'h3004; settle;
      tick; mem_rdata = 32'h77; settle;
      tick; mem_wait = 1'b1; settle;
      chk("ar_beat1_req", mem_req, 1'b1);
      chk("ar_beat1_addr", mem_addr, 32'h3008);
      rst = 1'b1; #1;
      chk("ar_req_async", mem_req, 1'b0);
      chk("ar_line_out_cleared", line_out, 128'h0);
      req_valid = 1'b0; mem_wait = 1'b0;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick; settle;
         chk("ar_no_line_valid", line_valid, 1'b0);
         chk("ar_idle_noreq", mem_req, 1'b0);
      end
      req_valid = 1'b1; req_addr = 32'h3004; settle;
      tick; settle;
      chk("ar_restart_addr", mem_addr, 32'h3004);
      for (int b = 0; b < 3; b++) begin tick; settle; end
      tick; settle;
      chk("ar_restart_line_valid", line_valid, 1'b1);
      req_valid = 1'b0;
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
